// File: rtl/id_hazard_ctrl_if.sv
// Signal bundle between the ID-stage hazard controller and the pipeline.
// StallCount/FlushCount exist only when ID_HAZARD_PERF_CNT_EN is defined.
interface id_hazard_ctrl_if;
  logic [4:0]  IF_ID_rs1Addr;
  logic [4:0]  IF_ID_rs2Addr;
  logic [4:0]  ID_EX_rd;
  logic        ID_EX_MemRead;
  logic        Jump;
  logic        BranchTaken;
  logic        EX_MEM_MemAccess;
  logic        DMemReady;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        ID_EX_Write;
  logic        EX_MEM_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        MemTimeout;
`ifdef ID_HAZARD_PERF_CNT_EN
  logic [31:0] StallCount;
  logic [31:0] FlushCount;
`endif

  modport master (
    output IF_ID_rs1Addr, IF_ID_rs2Addr, ID_EX_rd, ID_EX_MemRead,
    output Jump, BranchTaken, EX_MEM_MemAccess, DMemReady,
`ifdef ID_HAZARD_PERF_CNT_EN
    input  StallCount, FlushCount,
`endif
    input  PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
    input  IF_ID_Flush, ID_EX_Flush, MemTimeout
  );

  modport slave (
    input  IF_ID_rs1Addr, IF_ID_rs2Addr, ID_EX_rd, ID_EX_MemRead,
    input  Jump, BranchTaken, EX_MEM_MemAccess, DMemReady,
`ifdef ID_HAZARD_PERF_CNT_EN
    output StallCount, FlushCount,
`endif
    output PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
    output IF_ID_Flush, ID_EX_Flush, MemTimeout
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: memory-wait stall with timeout, branch/jump flush, load-use stall.
// Define ID_HAZARD_PERF_CNT_EN to add the StallCount/FlushCount performance counters.
module id_hazard_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            reset,
  id_hazard_ctrl_if.slave bus
);
  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT_CYC);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] wait_cnt_r;
  logic       mem_timeout_r;
  logic       load_use_s;
  logic       timeout_s;
  logic       pc_write_s;
  logic       if_id_write_s;
  logic       id_ex_write_s;
  logic       ex_mem_write_s;
  logic       if_id_flush_s;
  logic       id_ex_flush_s;

  assign load_use_s = bus.ID_EX_MemRead && (bus.ID_EX_rd != 5'd0) &&
                      ((bus.ID_EX_rd == bus.IF_ID_rs1Addr) ||
                       (bus.ID_EX_rd == bus.IF_ID_rs2Addr));

  // Next state and stage controls, highest priority first.
  always_comb begin
    state_nxt_s    = state_r;
    timeout_s      = 1'b0;
    pc_write_s     = 1'b1;
    if_id_write_s  = 1'b1;
    id_ex_write_s  = 1'b1;
    ex_mem_write_s = 1'b1;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    if (reset) begin
      state_nxt_s    = RUN;
      pc_write_s     = 1'b0;
      if_id_write_s  = 1'b0;
      id_ex_write_s  = 1'b0;
      ex_mem_write_s = 1'b0;
      if_id_flush_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (bus.EX_MEM_MemAccess && !bus.DMemReady) begin
            state_nxt_s    = MEM_WAIT;
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_write_s  = 1'b0;
            ex_mem_write_s = 1'b0;
          end else if (bus.BranchTaken) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
          end else if (load_use_s) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            id_ex_flush_s = 1'b1;
          end else if (bus.Jump) begin
            if_id_flush_s = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        MEM_WAIT: begin
          if (bus.DMemReady) begin
            state_nxt_s = RUN;
          end else begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_write_s  = 1'b0;
            ex_mem_write_s = 1'b0;
            if (wait_cnt_r == TIMEOUT_L) begin
              timeout_s   = 1'b1;
              state_nxt_s = RUN;
            end else begin
              state_nxt_s = MEM_WAIT;
            end
          end
        end
        default: begin
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // State, wait counter and sticky timeout flag; the counter is zero whenever MEM_WAIT is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= RUN;
      wait_cnt_r    <= 8'd0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r != MEM_WAIT) || timeout_s) begin
        wait_cnt_r <= 8'd0;
      end else if (wait_cnt_r != 8'hFF) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      mem_timeout_r <= mem_timeout_r | timeout_s;
    end
  end

  assign bus.PCWrite      = pc_write_s;
  assign bus.IF_ID_Write  = if_id_write_s;
  assign bus.ID_EX_Write  = id_ex_write_s;
  assign bus.EX_MEM_Write = ex_mem_write_s;
  assign bus.IF_ID_Flush  = if_id_flush_s;
  assign bus.ID_EX_Flush  = id_ex_flush_s;
  assign bus.MemTimeout   = mem_timeout_r;

`ifdef ID_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Performance counters; free-running and wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (!pc_write_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (if_id_flush_s || id_ex_flush_s) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bus.StallCount = stall_cnt_r;
  assign bus.FlushCount = flush_cnt_r;
`endif
endmodule
